// File: rtl/mfp_ahb_lite_interconnect_if.sv
// Bus bundle between the MIPSfpga master side and the interconnect's slave-facing ports.
// SLAVE_HUNG exists only when MFP_AHB_INTERCONNECT_TIMEOUT_EN is defined.
interface mfp_ahb_lite_interconnect_if #(
  parameter int N_SLAVES = 5
);
  logic [31:0]            HADDR;
  logic [1:0]             HTRANS;
  logic [31:0]            HRDATA;
  logic                   HREADY;
  logic                   HRESP;
  logic [N_SLAVES-1:0]    S_HSEL;
  logic [32*N_SLAVES-1:0] S_HRDATA;
  logic [N_SLAVES-1:0]    S_HREADYOUT;
  logic [N_SLAVES-1:0]    S_HRESP;
`ifdef MFP_AHB_INTERCONNECT_TIMEOUT_EN
  logic [N_SLAVES-1:0]    SLAVE_HUNG;

  modport master (
    output HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP,
    input  HRDATA, HREADY, HRESP, S_HSEL, SLAVE_HUNG
  );
  modport slave (
    input  HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP,
    output HRDATA, HREADY, HRESP, S_HSEL, SLAVE_HUNG
  );
`else
  modport master (
    output HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP,
    input  HRDATA, HREADY, HRESP, S_HSEL
  );
  modport slave (
    input  HADDR, HTRANS, S_HRDATA, S_HREADYOUT, S_HRESP,
    output HRDATA, HREADY, HRESP, S_HSEL
  );
`endif
endinterface

// File: rtl/mfp_ahb_lite_interconnect.sv
// Single-master AHB-Lite interconnect: base/mask decode, registered data-phase owner, response mux
// and a two-cycle ERROR default slave. MFP_AHB_INTERCONNECT_TIMEOUT_EN adds a hung-slave watchdog.
module mfp_ahb_lite_interconnect #(
  parameter int                     N_SLAVES       = 5,
  parameter logic [32*N_SLAVES-1:0] SLAVE_BASE     = {N_SLAVES{32'h0}},
  parameter logic [32*N_SLAVES-1:0] SLAVE_MASK     = {N_SLAVES{32'h0}},
  parameter int                     TIMEOUT_CYCLES = 256
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  mfp_ahb_lite_interconnect_if.slave bus,
  output logic [1:0]                 dbg_state_o,
  output logic                       dbg_dp_active_o
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ERR1 = 2'd1, ST_ERR2 = 2'd2} state_e;

  localparam logic [N_SLAVES:0] DP_DEFAULT = {1'b1, {N_SLAVES{1'b0}}};

  state_e              state_q, state_d;
  logic [N_SLAVES:0]   dp_sel_q, dp_sel_d;
  logic                dp_active_q, dp_active_d;
  logic [N_SLAVES-1:0] match, hsel, hung;
  logic                hit_found, dflt_sel, active, capture, timeout, hready;

  // Lowest matching index wins; a hung slave's select is dropped so the access falls to the default slave.
  always_comb begin
    match     = '0;
    hsel      = '0;
    hit_found = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      match[i] = ((bus.HADDR ^ SLAVE_BASE[32*i +: 32]) & SLAVE_MASK[32*i +: 32]) == 32'h0;
      if (match[i] && !hit_found) begin
        hsel[i]   = 1'b1;
        hit_found = 1'b1;
      end
    end
    hsel = hsel & ~hung;
  end

  assign bus.S_HSEL = hsel;
  assign dflt_sel   = ~|hsel;
  assign active     = (bus.HTRANS == 2'b10) || (bus.HTRANS == 2'b11);
  assign capture    = hready && active && dflt_sel;

  always_comb begin
    bus.HRDATA = 32'h0;
    hready     = 1'b0;
    bus.HRESP  = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (dp_sel_q[i]) begin
        bus.HRDATA = bus.S_HRDATA[32*i +: 32];
        hready     = bus.S_HREADYOUT[i];
        bus.HRESP  = bus.S_HRESP[i];
      end
    end
    if (dp_sel_q[N_SLAVES]) begin
      bus.HRDATA = 32'h0;
      hready     = (state_q != ST_ERR1);
      bus.HRESP  = (state_q != ST_IDLE);
    end
  end

  assign bus.HREADY = hready;

`ifdef MFP_AHB_INTERCONNECT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_SLAVES-1:0] hung_q, hung_d;
  logic                stall;

  always_comb begin
    stall   = dp_active_q && !dp_sel_q[N_SLAVES] && !hready;
    timeout = stall && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    cnt_d   = cnt_q;
    if (hready)     cnt_d = '0;
    else if (stall) cnt_d = cnt_q + 1'b1;
    hung_d  = hung_q | (timeout ? dp_sel_q[N_SLAVES-1:0] : '0);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q  <= '0;
      hung_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hung_q <= hung_d;
    end
  end

  assign hung           = hung_q;
  assign bus.SLAVE_HUNG = hung_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign hung    = '0;
  assign timeout = 1'b0;
`endif

  // A watchdog expiry hands the stalled data phase to the default slave so it can finish it with ERROR.
  always_comb begin
    dp_sel_d    = dp_sel_q;
    dp_active_d = dp_active_q;
    if (timeout) begin
      dp_sel_d = DP_DEFAULT;
    end else if (hready) begin
      dp_sel_d    = {dflt_sel, hsel};
      dp_active_d = active;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (timeout || capture) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = capture ? ST_ERR1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      dp_sel_q    <= DP_DEFAULT;
      dp_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dp_sel_q    <= dp_sel_d;
      dp_active_q <= dp_active_d;
    end
  end

  assign dbg_state_o     = state_q;
  assign dbg_dp_active_o = dp_active_q;
endmodule

// File: tb/tb_mfp_ahb_lite_interconnect.sv
// Directed bench for mfp_ahb_lite_interconnect: decode, wait states, default-slave ERROR, pipelining,
// and the watchdog when MFP_AHB_INTERCONNECT_TIMEOUT_EN is defined.
module tb_mfp_ahb_lite_interconnect;
  localparam int N = 5;
  // slot 0 reset RAM, 1 low RAM (bits 28:26 == 0), 2 GPIO, 3 overlaps slot 1, 4 UART
  localparam logic [32*N-1:0] BASE = {32'h1F810000, 32'h00000000, 32'h1F800000,
                                      32'h00000000, 32'h1FC00000};
  localparam logic [32*N-1:0] MASK = {32'hFFFF0000, 32'hF0000000, 32'hFFFF0000,
                                      32'h1C000000, 32'hFFC00000};
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10;

  logic       HCLK;
  logic       HRESETn;
  logic [1:0] dbg_state;
  logic       dbg_dp_active;

  int          checks_total  = 0;
  int          checks_passed = 0;
  logic [31:0] exp_q[$];

  mfp_ahb_lite_interconnect_if #(.N_SLAVES(N)) bus ();

  mfp_ahb_lite_interconnect #(
    .N_SLAVES(N), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus),
    .dbg_state_o(dbg_state), .dbg_dp_active_o(dbg_dp_active)
  );

  // clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // driver tasks: inputs change 1 time unit after posedge, outputs are sampled on negedge
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic sample();
    @(negedge HCLK);
  endtask

  task automatic set_slave(input int i, input logic rdy, input logic [31:0] data);
    bus.S_HREADYOUT[i]     = rdy;
    bus.S_HRDATA[32*i +: 32] = data;
  endtask

  task automatic drive_idle();
    bus.HADDR  = 32'h0;
    bus.HTRANS = T_IDLE;
    bus.S_HRESP = '0;
    for (int i = 0; i < N; i++) set_slave(i, 1'b1, 32'hA0A00000 | i);
  endtask

  task automatic check_beat(input string tag);
    if (exp_q.size() == 0) check({tag, "_queue_empty"}, 32'h1, 32'h0);
    else check(tag, bus.HRDATA, exp_q.pop_front());
  endtask

  initial begin
    HRESETn = 1'b0;
    drive_idle();

    // reset state
    repeat (2) @(posedge HCLK);
    sample();
    check("rst_hready", bus.HREADY, 1);
    check("rst_hresp",  bus.HRESP, 0);
    check("rst_hrdata", bus.HRDATA, 0);
    check("rst_state",  dbg_state, 0);
    tick(); HRESETn = 1'b1;
    sample();
    check("rel_hready", bus.HREADY, 1);
    check("rel_dp_active", dbg_dp_active, 0);

    // slave 0 read with two wait states
    tick(); bus.HADDR = 32'h1FC00010; bus.HTRANS = T_NONSEQ;
    sample();
    check("rd0_hsel", bus.S_HSEL, 5'b00001);
    check("rd0_addr_hready", bus.HREADY, 1);
    tick(); bus.HADDR = 32'h0; bus.HTRANS = T_IDLE; set_slave(0, 1'b0, 32'h0BAD0000);
    sample();
    check("rd0_wait1", bus.HREADY, 0);
    check("rd0_dp_active", dbg_dp_active, 1);
    tick();
    sample();
    check("rd0_wait2", bus.HREADY, 0);
    tick(); set_slave(0, 1'b1, 32'hDEADBEEF); set_slave(1, 1'b0, 32'h11110000);
    sample();
    check("rd0_done_hready", bus.HREADY, 1);
    check("rd0_done_hrdata", bus.HRDATA, 32'hDEADBEEF);
    check("rd0_done_hresp",  bus.HRESP, 0);
    tick(); drive_idle();

    // overlap decode; HTRANS is IDLE to show decode ignores it
    bus.HADDR = 32'h00001000;
    sample();
    check("ovl_slave1_wins", bus.S_HSEL, 5'b00010);
    tick(); bus.HADDR = 32'h04000000;
    sample();
    check("ovl_slave3_only", bus.S_HSEL, 5'b01000);
    tick(); bus.HADDR = 32'h1F810000;
    sample();
    check("dec_slave4", bus.S_HSEL, 5'b10000);

    // unmapped NONSEQ -> ERR1, ERR2
    tick(); bus.HADDR = 32'h30000000; bus.HTRANS = T_NONSEQ;
    sample();
    check("unm_hsel", bus.S_HSEL, 5'b00000);
    tick(); drive_idle();
    sample();
    check("unm_err1_hready", bus.HREADY, 0);
    check("unm_err1_hresp",  bus.HRESP, 1);
    check("unm_err1_state",  dbg_state, 1);
    check("unm_err1_hrdata", bus.HRDATA, 0);
    tick();
    sample();
    check("unm_err2_hready", bus.HREADY, 1);
    check("unm_err2_hresp",  bus.HRESP, 1);
    tick();
    sample();
    check("unm_after_hresp", bus.HRESP, 0);
    check("unm_after_state", dbg_state, 0);

    // same unmapped address with IDLE and BUSY -> zero-wait OKAY
    tick(); bus.HADDR = 32'h30000000; bus.HTRANS = T_IDLE;
    tick(); bus.HTRANS = T_BUSY;
    sample();
    check("unm_idle_hready", bus.HREADY, 1);
    check("unm_idle_hresp",  bus.HRESP, 0);
    tick(); drive_idle();
    sample();
    check("unm_busy_hready", bus.HREADY, 1);
    check("unm_busy_hresp",  bus.HRESP, 0);
    check("unm_busy_state",  dbg_state, 0);

    // mapped -> unmapped -> mapped, no gap cycle
    tick(); bus.HADDR = 32'h1FC00010; bus.HTRANS = T_NONSEQ;
    tick(); bus.HADDR = 32'h30000000; set_slave(0, 1'b1, 32'h11111111);
    sample();
    check("b2b_s0_hrdata", bus.HRDATA, 32'h11111111);
    check("b2b_s0_hready", bus.HREADY, 1);
    tick(); bus.HADDR = 32'h1F810000;
    sample();
    check("b2b_err1_hready", bus.HREADY, 0);
    check("b2b_err1_hresp",  bus.HRESP, 1);
    tick();
    sample();
    check("b2b_err2_hready", bus.HREADY, 1);
    check("b2b_err2_hresp",  bus.HRESP, 1);
    tick(); drive_idle(); set_slave(4, 1'b1, 32'h44444444);
    sample();
    check("b2b_s4_hrdata", bus.HRDATA, 32'h44444444);
    check("b2b_s4_hresp",  bus.HRESP, 0);
    check("b2b_s4_state",  dbg_state, 0);

    // slave 2 stalls three cycles while the pipelined address targets slave 4
    exp_q.push_back(32'h2222ABCD);
    exp_q.push_back(32'h4444ABCD);
    tick(); bus.HADDR = 32'h1F800004; bus.HTRANS = T_NONSEQ;
    tick(); bus.HADDR = 32'h1F810008;
    set_slave(2, 1'b0, 32'h22220001); set_slave(4, 1'b1, 32'h4444DEAD);
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) begin
        tick(); set_slave(2, 1'b0, 32'h22220000 | c);
      end
      sample();
      check($sformatf("pipe_stall%0d_hready", c), bus.HREADY, 0);
      check($sformatf("pipe_stall%0d_hrdata", c), bus.HRDATA, 32'h22220000 | c);
    end
    tick(); set_slave(2, 1'b1, 32'h2222ABCD);
    sample();
    check("pipe_s2_done_hready", bus.HREADY, 1);
    check_beat("pipe_beat_s2");
    tick(); drive_idle(); set_slave(4, 1'b1, 32'h4444ABCD); set_slave(2, 1'b0, 32'h22229999);
    sample();
    check("pipe_s4_hready", bus.HREADY, 1);
    check_beat("pipe_beat_s4");
    tick(); drive_idle();

`ifdef MFP_AHB_INTERCONNECT_TIMEOUT_EN
    // slave 3 hangs; watchdog limit is 8 stall cycles
    tick(); bus.HADDR = 32'h04000000; bus.HTRANS = T_NONSEQ;
    tick(); bus.HADDR = 32'h0; bus.HTRANS = T_IDLE; set_slave(3, 1'b0, 32'h33333333);
    for (int c = 1; c <= 8; c++) begin
      sample();
      check($sformatf("wdt_stall%0d", c), bus.HREADY, 0);
      tick();
    end
    sample();
    check("wdt_err1_hready", bus.HREADY, 0);
    check("wdt_err1_hresp",  bus.HRESP, 1);
    check("wdt_hung", bus.SLAVE_HUNG, 5'b01000);
    tick();
    sample();
    check("wdt_err2_hready", bus.HREADY, 1);
    check("wdt_err2_hresp",  bus.HRESP, 1);
    tick(); bus.HADDR = 32'h04000000; bus.HTRANS = T_NONSEQ;
    sample();
    check("wdt_reroute_hsel", bus.S_HSEL, 5'b00000);
    tick(); drive_idle();
    sample();
    check("wdt_reroute_err1", bus.HRESP, 1);
    tick(); HRESETn = 1'b0;
    sample();
    check("wdt_rst_hung", bus.SLAVE_HUNG, 5'b00000);
    tick(); HRESETn = 1'b1;
    bus.HADDR = 32'h04000000;
    sample();
    check("wdt_rst_hsel", bus.S_HSEL, 5'b01000);
    tick(); drive_idle();
`endif

    check("final_exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
